// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   state_t          - fetch FSM state encoding (BOOT, RUN, FLUSH)
//   RESET_PC_DEFAULT - default byte address of the first fetched instruction
//   *_HI / *_LO      - instruction field positions
//   INSTR_BYTES      - size of one instruction in bytes
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned FUNCT_HI  = 5;
  localparam int unsigned FUNCT_LO  = 0;
  localparam int unsigned IMM_HI    = 15;
  localparam int unsigned IMM_LO    = 0;
  localparam int unsigned INDEX_HI  = 25;
  localparam int unsigned INDEX_LO  = 0;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// pc_next_calc: combinational next-pc selection for the fetch unit.
//   pc            - address currently issued to the ROM
//   ir_pc         - byte address of the presented instruction
//   accept        - presented instruction is valid and being consumed
//   branch_taken  - taken branch for the presented instruction
//   branch_imm    - branch offset field (words, signed)
//   jump          - jump for the presented instruction
//   jump_index    - jump target field (words)
//   next_pc       - pc to issue on the next cycle when advancing
//   redirect      - an accepted branch or jump replaces sequential flow
module pc_next_calc
  import fetch_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [31:0]       ir_pc,
  input  logic              accept,
  input  logic              branch_taken,
  input  logic [IMM_HI:0]   branch_imm,
  input  logic              jump,
  input  logic [INDEX_HI:0] jump_index,
  output logic [31:0]       next_pc,
  output logic              redirect
);

  logic [31:0] pc_inc;
  logic [31:0] seq_ret;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  always_comb begin
    pc_inc        = pc + INSTR_BYTES;
    seq_ret       = ir_pc + INSTR_BYTES;
    branch_target = seq_ret + {{14{branch_imm[IMM_HI]}}, branch_imm, 2'b00};
    jump_target   = {seq_ret[31:28], jump_index, 2'b00};
    redirect      = accept & (jump | branch_taken);

    // jump outranks branch when both are flagged
    if (accept && jump) begin
      next_pc = jump_target;
    end else if (accept && branch_taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_inc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with stall, branch and jump
// redirect against a registered (one-cycle latency) instruction ROM.
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   rom_ena      - ROM read enable
//   rom_addr     - ROM word address (pc >> 2)
//   rom_data     - ROM read word, one cycle after the address
//   stall        - downstream not accepting the presented instruction
//   branch_taken - redirect to ir_pc + 4 + (sext(branch_imm) << 2)
//   branch_imm   - branch offset field
//   jump         - redirect to {(ir_pc + 4)[31:28], jump_index, 2'b00}
//   jump_index   - jump target field
//   ir           - presented instruction (straight from rom_data)
//   ir_pc        - byte address of ir
//   ir_valid     - ir / ir_pc hold a real instruction
//   fetch_count  - number of instructions consumed
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ena,
  output logic [31:0]       rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [IMM_HI:0]   branch_imm,
  input  logic              jump,
  input  logic [INDEX_HI:0] jump_index,
  output logic [31:0]       ir,
  output logic [31:0]       ir_pc,
  output logic              ir_valid,
  output logic [31:0]       fetch_count
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_pc_q;
  logic        ir_valid_q;
  logic [31:0] fetch_count_q;

  logic        hold;
  logic        accept;
  logic        redirect;
  logic [31:0] next_pc;

  // Only RUN with a valid instruction honours stall; BOOT and FLUSH always
  // advance so the pipeline refills.
  assign hold   = (state_q == RUN) && stall && ir_valid_q;
  assign accept = (state_q == RUN) && ir_valid_q && !stall;

  pc_next_calc u_pc_next_calc (
    .pc           (pc_q),
    .ir_pc        (ir_pc_q),
    .accept       (accept),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .next_pc      (next_pc),
    .redirect     (redirect)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (!hold) begin
        pc_q       <= next_pc;
        ir_pc_q    <= pc_q;
        // the word fetched on a redirect edge is the dropped delay slot
        ir_valid_q <= !redirect;
      end
      if (ir_valid_q && !stall) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end
  end

  // rom_ena is gated by rst so it drops immediately on reset assertion
  assign rom_ena     = rst && !hold;
  assign rom_addr    = {2'b00, pc_q[31:2]};
  assign ir          = rom_data;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rom_ena;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ena      (rom_ena),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ROM: word at word-address a is C000_0000 ^ a, held when disabled
  initial rom_data = '0;
  always @(posedge clk) if (rom_ena) rom_data <= 32'hC000_0000 ^ rom_addr;

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return 32'hC000_0000 ^ {2'b00, byte_addr[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] hold_ir;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  initial begin
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_imm = '0;
    jump = 1'b0; jump_index = '0;
    #3;
    chk("rst_rom_ena", {31'd0, rom_ena}, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir_pc", ir_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);

    @(negedge clk); rst = 1'b1; #1;
    chk("boot_rom_ena", {31'd0, rom_ena}, 32'd1);
    chk("boot_ir_valid", {31'd0, ir_valid}, 32'd0);

    // sequential fetch: ir_pc 0,4,8,12 with rom_addr 1..4
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_rom_addr", rom_addr, 32'(i + 1));
      chk("seq_ir_pc", ir_pc, 32'(i * 4));
      chk("seq_ir_valid", {31'd0, ir_valid}, 32'd1);
      chk("seq_ir", ir, word_at(32'(i * 4)));
      chk("seq_count", fetch_count, 32'(i));
    end
    step(); step(); step();
    chk("pre_stall_ir_pc", ir_pc, 32'h18);
    chk("pre_stall_count", fetch_count, 32'd6);

    // stall three cycles at ir_pc 0x18
    stall = 1'b1; #1;
    chk("stall_rom_ena", {31'd0, rom_ena}, 32'd0);
    hold_ir = word_at(32'h18);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rom_ena_h", {31'd0, rom_ena}, 32'd0);
      chk("stall_ir_pc", ir_pc, 32'h18);
      chk("stall_ir", ir, hold_ir);
      chk("stall_count", fetch_count, 32'd6);
      chk("stall_rom_addr", rom_addr, 32'h7);
    end
    stall = 1'b0;
    step();
    chk("unstall_ir_pc", ir_pc, 32'h1C);
    chk("unstall_count", fetch_count, 32'd7);
    step();
    chk("pre_br_ir_pc", ir_pc, 32'h20);

    // backward branch at 0x20, imm -2 -> target 0x1C
    branch_taken = 1'b1; branch_imm = 16'hFFFE;
    step();
    branch_taken = 1'b0; branch_imm = '0;
    chk("br_bubble_valid", {31'd0, ir_valid}, 32'd0);
    chk("br_rom_addr", rom_addr, 32'h7);
    chk("br_rom_ena", {31'd0, rom_ena}, 32'd1);
    chk("br_count", fetch_count, 32'd9);
    step();
    chk("br_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("br_ir_pc", ir_pc, 32'h1C);
    chk("br_ir", ir, word_at(32'h1C));
    chk("br_rom_addr2", rom_addr, 32'h8);
    chk("br_count2", fetch_count, 32'd9);

    // walk forward to 0x40
    exp_pc = 32'h1C; exp_cnt = 32'd9;
    for (int i = 0; i < 9; i++) begin
      step();
      exp_pc = exp_pc + 32'd4; exp_cnt = exp_cnt + 32'd1;
      chk("walk_ir_pc", ir_pc, exp_pc);
      chk("walk_ir", ir, word_at(exp_pc));
    end
    chk("walk_end_pc", ir_pc, 32'h40);
    chk("walk_count", fetch_count, 32'd18);

    // jump + branch together at 0x40: jump target 0x40 wins over branch 0x84
    jump = 1'b1; branch_taken = 1'b1; jump_index = 26'h10; branch_imm = 16'h0010;
    step();
    jump = 1'b0; branch_taken = 1'b0; jump_index = '0; branch_imm = '0;
    chk("jmp_bubble_valid", {31'd0, ir_valid}, 32'd0);
    chk("jmp_rom_addr", rom_addr, 32'h10);
    step();
    chk("jmp_ir_pc", ir_pc, 32'h40);
    chk("jmp_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("jmp_count", fetch_count, 32'd19);

    // branch imm 0 -> FLUSH, then reset mid-FLUSH without a clock edge
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    chk("fl_valid", {31'd0, ir_valid}, 32'd0);
    chk("fl_rom_addr", rom_addr, 32'h11);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rom_ena", {31'd0, rom_ena}, 32'd0);
    chk("mid_rst_ir_pc", ir_pc, 32'd0);
    chk("mid_rst_count", fetch_count, 32'd0);
    chk("mid_rst_rom_addr", rom_addr, 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rb_rom_ena", {31'd0, rom_ena}, 32'd1);
    chk("rb_valid", {31'd0, ir_valid}, 32'd0);
    step();
    chk("rb_ir_pc", ir_pc, 32'd0);
    chk("rb_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("rb_rom_addr", rom_addr, 32'd1);

    // backdoor preload, then two consumed instructions wrap the counter
    dut.fetch_count_q = 32'hFFFF_FFFF;
    step();
    chk("wrap0", fetch_count, 32'd0);
    step();
    chk("wrap1", fetch_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetched instruction (word aligned).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rom_ena  out  1  read enable to the instruction ROM.
REQ-005 SHALL have port rom_addr  out  32  ROM word address, equal to pc>>2 with the top two bits zero.
REQ-006 SHALL have port rom_data  in  32  ROM read word, registered in the ROM, valid one cycle after the address is sampled with rom_ena=1, and held while rom_ena=0.
REQ-007 SHALL have port stall  in  1  downstream not accepting the presented instruction.
REQ-008 SHALL have port branch_taken  in  1  taken branch for the presented instruction.
REQ-009 SHALL have port branch_imm  in  16  branch offset field IR[15:0].
REQ-010 SHALL have port jump  in  1  jump for the presented instruction.
REQ-011 SHALL have port jump_index  in  26  jump target field IR[25:0].
REQ-012 SHALL have port ir  out  32  presented instruction, driven directly from rom_data.
REQ-013 SHALL have port ir_pc  out  32  byte address of ir.
REQ-014 SHALL have port ir_valid  out  1  ir/ir_pc hold a real instruction.
REQ-015 SHALL have port fetch_count  out  32  count of instructions consumed.

Function
REQ-016 SHALL implement states BOOT, RUN and FLUSH; pc SHALL be the address currently issued to the ROM.
REQ-017 BOOT SHALL last one cycle: rom_ena=1 and pc=RESET_PC; next state RUN with ir_pc=RESET_PC, ir_valid=1 and pc=RESET_PC+4.
REQ-018 In RUN with stall=0, each edge SHALL set ir_pc<=pc and pc<=pc+4, modulo 2^32.
REQ-019 In RUN with stall=1 and ir_valid=1, rom_ena SHALL be 0 and pc, ir_pc, ir_valid and fetch_count SHALL hold.
REQ-020 A redirect SHALL be accepted only when ir_valid=1 and stall=0; otherwise branch_taken and jump SHALL be ignored.
REQ-021 The branch target SHALL be ir_pc+4+(sign_extend(branch_imm)<<2), modulo 2^32.
REQ-022 The jump target SHALL be {(ir_pc+4)[31:28], jump_index, 2'b00}.
REQ-023 When jump and branch_taken are both asserted, the jump SHALL take priority.
REQ-024 On an accepted redirect, the same edge SHALL set pc<=target, ir_valid<=0 and state<=FLUSH, and SHALL discard the in-flight word; there SHALL be no delay slot.
REQ-025 FLUSH SHALL last one cycle with rom_ena=1 and ir_valid=0, ignoring stall; next state RUN with ir_pc=target, ir_valid=1 and pc=target+4.
REQ-026 fetch_count SHALL increment by 1 on each edge where ir_valid=1 and stall=0, wrapping from 32'hFFFF_FFFF to 0.
REQ-027 rom_ena SHALL be 1 in every state except RUN with stall=1 and ir_valid=1.

Reset
REQ-028 While rst=0, outputs SHALL be forced immediately, independent of clk: state=BOOT, pc=RESET_PC, ir_pc=0, ir_valid=0, fetch_count=0, rom_ena=0.
REQ-029 The first rising edge after rst deasserts SHALL begin the BOOT cycle; reset mid-stall or mid-FLUSH SHALL discard all pending work.

Structure
REQ-030 A shared package fetch_pkg SHALL hold the state encoding, RESET_PC default, the instruction field positions (opcode 31:26, funct 5:0, imm 15:0, index 25:0) and the constant 32'd4.
REQ-031 A single combinational sub-module pc_next_calc SHALL compute the pc+4, branch-target and jump-target values and the priority mux.

Verification
REQ-032 Release reset, then run 4 edges with stall=0 -> rom_addr=0,1,2,3,4; ir_valid rises after the first edge; ir_pc=0,4,8,12; fetch_count=3.
REQ-033 Set stall=1 for 3 cycles while ir_pc=0x18 -> rom_ena=0, and ir, ir_pc and fetch_count stay constant; after release, ir_pc=0x1C next cycle.
REQ-034 Apply branch_taken=1 with branch_imm=16'hFFFE at ir_pc=0x20 -> one cycle with ir_valid=0, then ir_pc=0x1C (rom_addr 7), and the 0x24 word is never presented.
REQ-035 Apply jump=1 and branch_taken=1 together with jump_index=26'h10 at ir_pc=0x40 -> ir_pc=0x40 after the bubble, so the jump wins.
REQ-036 Pull rst low mid-FLUSH -> outputs take reset values without a clock edge; after release, the restart is from RESET_PC.
REQ-037 Preload fetch_count near 32'hFFFF_FFFF via a 2^32-cycle force or backdoor, then consume two instructions -> fetch_count wraps to 32'h0000_0001.
